com_link_master: RTL and testbench

Host-side endpoint of the team's ASCII hex register link, for use when one FPGA drives a peer register bridge over UART instead of a PC. The block turns parallel register writes into `S<reg><hi><lo>` command strings and parses the peer's `D<chan><hi><lo>\n` report strings back into parallel data with a valid strobe. It instantiates the team's `uart_tx` and `uart_rx` modules and sits between user logic and the serial pins.

---
 rtl/com_link_master.sv | 328 ++++++++++++++++++++++++++++++++
 tb/tb_com_link_master.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/com_link_master.sv
// com_link_master: turns register writes into "S<r><h><l>" strings and parses "D<c><h><l>\n" reports.
// Defining COM_LINK_ERRCNT_EN builds the saturating malformed-report counter behind ERR_COUNT.
`timescale 1ns/1ps

module uart_tx #(
  parameter int CLK_FREQ = 12_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       CLK,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx
);
  localparam int CPB = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(CPB + 1);

  logic [CW-1:0] baud_cnt_reg;
  logic [3:0]    bit_idx_reg;
  logic [7:0]    shift_reg;
  logic          busy_reg;

  // bit_idx 0 is the start bit, 1..8 data LSB first, 9 the stop bit
  always_ff @(posedge CLK) begin
    if (!busy_reg) begin
      if (tx_start) begin
        busy_reg     <= 1'b1;
        shift_reg    <= tx_data;
        bit_idx_reg  <= 4'd0;
        baud_cnt_reg <= '0;
      end
    end else if (baud_cnt_reg == CW'(CPB - 1)) begin
      baud_cnt_reg <= '0;
      if (bit_idx_reg == 4'd9) begin
        busy_reg <= 1'b0;
      end else begin
        bit_idx_reg <= bit_idx_reg + 4'd1;
        if (bit_idx_reg != 4'd0) shift_reg <= {1'b0, shift_reg[7:1]};
      end
    end else begin
      baud_cnt_reg <= baud_cnt_reg + 1'b1;
    end
  end

  assign tx_busy = busy_reg;
  assign tx = !busy_reg ? 1'b1 :
              (bit_idx_reg == 4'd0) ? 1'b0 :
              (bit_idx_reg == 4'd9) ? 1'b1 : shift_reg[0];
endmodule

module uart_rx #(
  parameter int CLK_FREQ = 12_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       CLK,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_ready
);
  localparam int CPB  = CLK_FREQ / BAUD;
  localparam int CW   = $clog2(CPB + 1);
  localparam int HALF = CPB / 2 - 1;

  logic [1:0]    sync_reg;
  logic          prev_reg;
  logic          active_reg;
  logic [CW-1:0] cnt_reg;
  logic [3:0]    idx_reg;
  logic [7:0]    shift_reg;
  logic [7:0]    data_reg;
  logic          ready_reg;
  logic          rx_s;

  assign rx_s = sync_reg[1];

  // Start is a falling edge so power-up zeros in the synchroniser never fake a frame
  always_ff @(posedge CLK) begin
    sync_reg  <= {sync_reg[0], rx};
    prev_reg  <= rx_s;
    ready_reg <= 1'b0;
    if (!active_reg) begin
      if (prev_reg && !rx_s) begin
        active_reg <= 1'b1;
        cnt_reg    <= '0;
        idx_reg    <= 4'd0;
      end
    end else if (cnt_reg == ((idx_reg == 4'd0) ? CW'(HALF) : CW'(CPB - 1))) begin
      cnt_reg <= '0;
      if (idx_reg == 4'd0) begin
        if (rx_s) active_reg <= 1'b0;
        else      idx_reg    <= 4'd1;
      end else if (idx_reg <= 4'd8) begin
        shift_reg <= {rx_s, shift_reg[7:1]};
        idx_reg   <= idx_reg + 4'd1;
      end else begin
        active_reg <= 1'b0;
        if (rx_s) begin
          data_reg  <= shift_reg;
          ready_reg <= 1'b1;
        end
      end
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign rx_data  = data_reg;
  assign rx_ready = ready_reg;
endmodule

module com_link_master #(
  parameter int CLK_FREQ = 12_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       RX,
  output logic       TX,
  input  logic [3:0] WR_REG,
  input  logic [7:0] WR_DATA,
  input  logic       WR_VALID,
  output logic       WR_READY,
  output logic [2:0] RD_CHAN,
  output logic [7:0] RD_DATA,
  output logic       RD_VALID,
  output logic [7:0] ERR_COUNT
);
  typedef enum logic [2:0] {T_IDLE, T_S, T_REG, T_HI, T_LO} tx_state_t;
  typedef enum logic [2:0] {R_IDLE, R_CHAN, R_HI, R_LO, R_EOL} rx_state_t;

  function automatic logic [7:0] hex_enc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // {valid, value}; only uppercase hex digits are accepted
  function automatic logic [4:0] hex_dec(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39)      return {1'b1, c[3:0]};
    else if (c >= 8'h41 && c <= 8'h46) return {1'b1, c[3:0] + 4'd9};
    else                               return 5'd0;
  endfunction

  tx_state_t  tx_state_reg, tx_state_next;
  logic [3:0] wr_idx_reg, wr_idx_next;
  logic [7:0] wr_data_reg, wr_data_next;
  logic       tx_start_reg, tx_start_next;
  logic [7:0] tx_data_reg, tx_data_next;
  logic [7:0] tx_char;
  logic       tx_busy;
  logic       wr_ready;

  rx_state_t  rx_state_reg, rx_state_next;
  logic [2:0] chan_reg, chan_next;
  logic [3:0] hi_reg, hi_next;
  logic [3:0] lo_reg, lo_next;
  logic [2:0] rd_chan_reg, rd_chan_next;
  logic [7:0] rd_data_reg, rd_data_next;
  logic       rd_valid_reg, rd_valid_next;
  logic [7:0] rx_byte;
  logic       rx_ready;
  logic [4:0] rx_dec;
  logic       rx_is_d;
  logic       rx_ok;

  uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_tx (
    .CLK      (CLK),
    .tx_start (tx_start_reg),
    .tx_data  (tx_data_reg),
    .tx_busy  (tx_busy),
    .tx       (TX)
  );

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_rx (
    .CLK      (CLK),
    .rx       (RX),
    .rx_data  (rx_byte),
    .rx_ready (rx_ready)
  );

  // ---------------- transmit side ----------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tx_state_reg <= T_IDLE;
      wr_idx_reg   <= 4'h0;
      wr_data_reg  <= 8'h00;
      tx_start_reg <= 1'b0;
      tx_data_reg  <= 8'h00;
    end else begin
      tx_state_reg <= tx_state_next;
      wr_idx_reg   <= wr_idx_next;
      wr_data_reg  <= wr_data_next;
      tx_start_reg <= tx_start_next;
      tx_data_reg  <= tx_data_next;
    end
  end

  always_comb begin
    tx_char = 8'h53;
    case (tx_state_reg)
      T_REG:   tx_char = hex_enc(wr_idx_reg);
      T_HI:    tx_char = hex_enc(wr_data_reg[7:4]);
      T_LO:    tx_char = hex_enc(wr_data_reg[3:0]);
      default: tx_char = 8'h53;
    endcase
  end

  // The uart may still be finishing a character after reset, so busy gates readiness too
  assign wr_ready = (tx_state_reg == T_IDLE) && !tx_busy;
  assign WR_READY = RST_N && wr_ready;

  always_comb begin
    tx_state_next = tx_state_reg;
    wr_idx_next   = wr_idx_reg;
    wr_data_next  = wr_data_reg;
    tx_start_next = tx_start_reg;
    tx_data_next  = tx_data_reg;
    if (tx_state_reg == T_IDLE) begin
      if (WR_VALID && wr_ready) begin
        wr_idx_next   = WR_REG;
        wr_data_next  = WR_DATA;
        tx_state_next = T_S;
      end
    end else if (!tx_start_reg && !tx_busy) begin
      tx_data_next  = tx_char;
      tx_start_next = 1'b1;
    end else if (tx_start_reg && tx_busy) begin
      tx_start_next = 1'b0;
      case (tx_state_reg)
        T_S:     tx_state_next = T_REG;
        T_REG:   tx_state_next = T_HI;
        T_HI:    tx_state_next = T_LO;
        default: tx_state_next = T_IDLE;
      endcase
    end
  end

  // ---------------- receive side ----------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_state_reg <= R_IDLE;
      chan_reg     <= 3'd0;
      hi_reg       <= 4'h0;
      lo_reg       <= 4'h0;
      rd_chan_reg  <= 3'd0;
      rd_data_reg  <= 8'h00;
      rd_valid_reg <= 1'b0;
    end else begin
      rx_state_reg <= rx_state_next;
      chan_reg     <= chan_next;
      hi_reg       <= hi_next;
      lo_reg       <= lo_next;
      rd_chan_reg  <= rd_chan_next;
      rd_data_reg  <= rd_data_next;
      rd_valid_reg <= rd_valid_next;
    end
  end

  assign rx_dec  = hex_dec(rx_byte);
  assign rx_is_d = (rx_byte == 8'h44);

  // "D" always restarts a frame, so it never counts as a data digit
  always_comb begin
    rx_ok = 1'b0;
    case (rx_state_reg)
      R_CHAN:     rx_ok = (rx_byte[7:3] == 5'b00110);
      R_HI, R_LO: rx_ok = rx_dec[4] && !rx_is_d;
      R_EOL:      rx_ok = (rx_byte == 8'h0A);
      default:    rx_ok = 1'b0;
    endcase
  end

  always_comb begin
    rx_state_next = rx_state_reg;
    chan_next     = chan_reg;
    hi_next       = hi_reg;
    lo_next       = lo_reg;
    rd_chan_next  = rd_chan_reg;
    rd_data_next  = rd_data_reg;
    rd_valid_next = 1'b0;
    if (rx_ready) begin
      if (rx_state_reg == R_IDLE) begin
        if (rx_is_d) rx_state_next = R_CHAN;
      end else if (rx_ok) begin
        case (rx_state_reg)
          R_CHAN: begin
            chan_next     = rx_byte[2:0];
            rx_state_next = R_HI;
          end
          R_HI: begin
            hi_next       = rx_dec[3:0];
            rx_state_next = R_LO;
          end
          R_LO: begin
            lo_next       = rx_dec[3:0];
            rx_state_next = R_EOL;
          end
          default: begin
            rd_chan_next  = chan_reg;
            rd_data_next  = {hi_reg, lo_reg};
            rd_valid_next = 1'b1;
            rx_state_next = R_IDLE;
          end
        endcase
      end else begin
        rx_state_next = rx_is_d ? R_CHAN : R_IDLE;
      end
    end
  end

  assign RD_CHAN  = rd_chan_reg;
  assign RD_DATA  = rd_data_reg;
  assign RD_VALID = rd_valid_reg;

`ifdef COM_LINK_ERRCNT_EN
  logic [7:0] err_cnt_reg;
  logic       rx_err;

  assign rx_err = rx_ready && (rx_state_reg != R_IDLE) && !rx_ok;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                                err_cnt_reg <= 8'h00;
    else if (rx_err && err_cnt_reg != 8'hFF)   err_cnt_reg <= err_cnt_reg + 8'd1;
  end

  assign ERR_COUNT = err_cnt_reg;
`else
  assign ERR_COUNT = 8'h00;
`endif
endmodule

// File: tb/tb_com_link_master.sv
// Bench for com_link_master: serial driver/monitor on the pins, expectations built from the report/command string rules.
`timescale 1ns/1ps

module tb_com_link_master;
  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 100_000;
  localparam int CPB      = CLK_FREQ / BAUD;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       RX = 1'b1;
  logic       TX;
  logic [3:0] WR_REG = 4'h0;
  logic [7:0] WR_DATA = 8'h00;
  logic       WR_VALID = 1'b0;
  logic       WR_READY;
  logic [2:0] RD_CHAN;
  logic [7:0] RD_DATA;
  logic       RD_VALID;
  logic [7:0] ERR_COUNT;

  always #5 CLK = ~CLK;

  com_link_master #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .RX        (RX),
    .TX        (TX),
    .WR_REG    (WR_REG),
    .WR_DATA   (WR_DATA),
    .WR_VALID  (WR_VALID),
    .WR_READY  (WR_READY),
    .RD_CHAN   (RD_CHAN),
    .RD_DATA   (RD_DATA),
    .RD_VALID  (RD_VALID),
    .ERR_COUNT (ERR_COUNT)
  );

  int          chk_cnt = 0;
  int          pass_cnt = 0;
  byte unsigned tx_q[$];
  logic [10:0] rd_q[$];
  int          valid_long = 0;
  logic        rd_prev = 1'b0;

  // Model of the link state as seen from outside
  int          exp_err = 0;
  logic [2:0]  exp_chan = 3'd0;
  logic [7:0]  exp_data = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 10) ? 8'(48 + n) : 8'(55 + n);
  endfunction

  function automatic logic [7:0] exp_errcount();
`ifdef COM_LINK_ERRCNT_EN
    return (exp_err > 255) ? 8'hFF : 8'(exp_err);
`else
    return 8'h00;
`endif
  endfunction

  // Serial monitor on TX: decodes 8N1 characters sampled mid-bit
  initial begin : tx_mon
    logic [7:0] b;
    forever begin
      @(negedge TX);
      repeat (CPB / 2) @(negedge CLK);
      if (TX == 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge CLK);
          b[i] = TX;
        end
        repeat (CPB) @(negedge CLK);
        if (TX) tx_q.push_back(b);
      end
    end
  end

  always @(negedge CLK) begin
    if (RD_VALID) rd_q.push_back({RD_CHAN, RD_DATA});
    if (RD_VALID && rd_prev) valid_long++;
    rd_prev <= RD_VALID;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge CLK);
    RX = 1'b0;
    repeat (CPB) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (CPB) @(negedge CLK);
    end
    RX = 1'b1;
    repeat (CPB + 4) @(negedge CLK);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(8'(s[i]));
  endtask

  // Compare pulses seen since the last call and the held outputs against the model
  task automatic check_frame(input string tag, input int exp_pulses);
    logic [10:0] v;
    repeat (4) @(negedge CLK);
    check({tag, "_npulse"}, rd_q.size(), exp_pulses);
    if (rd_q.size() == 1) begin
      v = rd_q.pop_front();
      check({tag, "_pulse"}, v, {exp_chan, exp_data});
    end
    rd_q.delete();
    check({tag, "_chan"}, RD_CHAN, exp_chan);
    check({tag, "_data"}, RD_DATA, exp_data);
    check({tag, "_err"}, ERR_COUNT, exp_errcount());
    $display("report %s: RD_CHAN=%0d RD_DATA=0x%02h ERR_COUNT=%0d", tag, RD_CHAN, RD_DATA, ERR_COUNT);
  endtask

  task automatic do_write(input logic [3:0] r, input logic [7:0] d);
    int n;
    logic [7:0] exp_s[4];
    exp_s[0] = 8'h53;
    exp_s[1] = hexc(r);
    exp_s[2] = hexc(d[7:4]);
    exp_s[3] = hexc(d[3:0]);
    n = 0;
    while (!WR_READY && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    check("wr_ready_idle", WR_READY, 1);
    tx_q.delete();
    WR_REG = r;
    WR_DATA = d;
    WR_VALID = 1'b1;
    @(negedge CLK);
    WR_VALID = 1'b0;
    check("wr_ready_drop", WR_READY, 0);
    n = 1;
    while (!WR_READY && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    check("wr_done", WR_READY, 1);
    check("wr_duration", (n >= 40 * CPB && n <= 40 * CPB + 40), 1);
    check("wr_nchars", tx_q.size(), 4);
    for (int i = 0; i < 4; i++)
      check("wr_char", (i < tx_q.size()) ? 32'(tx_q[i]) : 32'hFFFF, 32'(exp_s[i]));
    $display("write reg=0x%0h data=0x%02h: %0d chars in %0d cycles", r, d, tx_q.size(), n);
  endtask

  initial begin : watchdog
    #3ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int njunk, kind, k;
    logic [7:0] b, d, bad;
    logic [2:0] c;
    logic [7:0] fld[3];

    repeat (3) @(negedge CLK);
    check("rst_wr_ready", WR_READY, 0);
    check("rst_rd_valid", RD_VALID, 0);
    check("rst_rd_chan", RD_CHAN, 0);
    check("rst_rd_data", RD_DATA, 0);
    check("rst_err", ERR_COUNT, 0);
    check("rst_tx_idle", TX, 1);
    RST_N = 1'b1;
    repeat (5) @(negedge CLK);

    do_write(4'h1, 8'hA5);

    send_str("D13C\n");
    exp_chan = 3'd1; exp_data = 8'h3C;
    check_frame("basic", 1);

    send_str("D9");
    exp_err++;
    check_frame("bad_chan", 0);
    send_str("D0FF\n");
    exp_chan = 3'd0; exp_data = 8'hFF;
    check_frame("after_bad", 1);

    send_str("x\nD2D007\n");
    exp_err++;
    exp_chan = 3'd0; exp_data = 8'h07;
    check_frame("resync", 1);

    fork
      do_write(4'h0, 8'hFF);
      send_str("D700\n");
    join
    exp_chan = 3'd7; exp_data = 8'h00;
    check_frame("duplex", 1);

    // Randomised frames: idle junk, then a clean, truncated or resynchronised report
    for (int f = 0; f < 12; f++) begin
      njunk = $urandom_range(0, 2);
      for (int j = 0; j < njunk; j++) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'h44) b = 8'h64;
        send_byte(b);
      end
      kind = $urandom_range(0, 2);
      c = 3'($urandom_range(0, 7));
      d = 8'($urandom);
      if (d[7:4] == 4'hD) d[7:4] = 4'h0;
      if (d[3:0] == 4'hD) d[3:0] = 4'h0;
      fld[0] = 8'h30 + {5'd0, c};
      fld[1] = hexc(d[7:4]);
      fld[2] = hexc(d[3:0]);
      case ($urandom_range(0, 2))
        0:       bad = 8'h78;
        1:       bad = 8'h47;
        default: bad = 8'h20;
      endcase
      if (kind != 0) begin
        k = $urandom_range(0, 3);
        send_byte(8'h44);
        for (int i = 0; i < k; i++) send_byte(fld[i]);
        send_byte(kind == 1 ? bad : 8'h44);
        exp_err++;
      end else begin
        send_byte(8'h44);
      end
      if (kind != 1) begin
        for (int i = 0; i < 3; i++) send_byte(fld[i]);
        send_byte(8'h0A);
        exp_chan = c;
        exp_data = d;
      end
      check_frame("random", (kind != 1) ? 1 : 0);
    end

    send_str("D4");
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    check("midrst_wr_ready", WR_READY, 0);
    check("midrst_rd_valid", RD_VALID, 0);
    RST_N = 1'b1;
    exp_err = 0; exp_chan = 3'd0; exp_data = 8'h00;
    send_str("12\n");
    check_frame("post_reset", 0);

    send_str("D5A1\n");
    exp_chan = 3'd5; exp_data = 8'hA1;
    check_frame("recover", 1);

    check("valid_one_cycle", valid_long, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
